// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl: CPU request/response channel plus the memory beat channel.
// master = the controller's view; slave = the CPU/memory environment's view.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_err, resp_rdata,
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_err, resp_rdata,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: lane mapping, two-beat misaligned split, read merge, extension, timeout.
//   state | meaning
//   IDLE  | req_ready=1, waiting for a request
//   BEAT0 | first aligned beat (entry cycle sets up the beat, then mem_req held until ack)
//   BEAT1 | second beat of a split access, issued back-to-back after BEAT0's ack
//   RESP  | one-cycle resp_valid pulse, then back to IDLE
module mem_access_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int BIG_ENDIAN     = 1,
    parameter int MISALIGN_SPLIT = 1,
    parameter int TIMEOUT        = 16
) (
    input logic           clock,
    input logic           reset_n,
    mem_access_ctrl_if.master bus
);
    localparam int NB    = DATA_W / 8;
    localparam int L     = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state;
    logic              write_q;
    logic              signed_q;
    logic              split_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [CNT_W-1:0]  wait_cnt;

    int   in_off;
    int   in_bytes;
    logic in_split;
    logic in_err;

    always_comb begin
        in_off   = int'(bus.req_addr[L-1:0]);
        in_bytes = 1 << bus.req_size;
        in_split = (in_off + in_bytes) > NB;
        in_err   = (in_bytes > NB) || (in_split && (MISALIGN_SPLIT == 0));
    end

    // Two-word window: lanes 0..NB-1 belong to BEAT0, NB..2NB-1 to BEAT1.
    logic [2*NB-1:0]   we_win;
    logic [2*DATA_W-1:0] wd_win;
    logic [2*DATA_W-1:0] rd_win;
    logic [DATA_W-1:0] rd_res;
    logic [DATA_W-1:0] load_result;
    int                size_bytes;
    int                pos;
    int                lane;
    int                src;

    always_comb begin
        size_bytes = 1 << size_q;
        if (size_bytes > NB) size_bytes = NB;
        we_win     = '0;
        wd_win     = '0;
        rd_res     = '0;
        pos        = 0;
        lane       = 0;
        src        = 0;
        rd_win     = {bus.mem_rdata, (state == BEAT1) ? merge_q : bus.mem_rdata};
        for (int k = 0; k < NB; k++) begin
            if (k < size_bytes) begin
                pos  = int'(addr_q[L-1:0]) + k;
                lane = (BIG_ENDIAN != 0) ? (pos / NB) * NB + (NB - 1 - (pos % NB)) : pos;
                src  = (BIG_ENDIAN != 0) ? size_bytes - 1 - k : k;
                we_win[lane]          = 1'b1;
                wd_win[8*lane +: 8]   = wdata_q[8*src +: 8];
                rd_res[8*src +: 8]    = rd_win[8*lane +: 8];
            end
        end
        load_result = rd_res;
        if (signed_q && (size_bytes < NB)) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (i >= 8 * size_bytes) load_result[i] = rd_res[8*size_bytes-1];
            end
        end
    end

    logic beat_done;
    logic timed_out;

    always_comb begin
        beat_done = bus.mem_req && bus.mem_ack;
        timed_out = bus.mem_req && !bus.mem_ack && (wait_cnt == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            signed_q       <= 1'b0;
            split_q        <= 1'b0;
            size_q         <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            merge_q        <= '0;
            wait_cnt       <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q       <= bus.req_write;
                        signed_q      <= bus.req_signed;
                        size_q        <= bus.req_size;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        split_q       <= in_split;
                        bus.req_ready <= 1'b0;
                        if (in_err) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            state <= BEAT0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if ((state == BEAT0) && !bus.mem_req) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= addr_q & ~LANE_MASK;
                        bus.mem_we    <= write_q ? we_win[NB-1:0] : '0;
                        bus.mem_wdata <= write_q ? wd_win[DATA_W-1:0] : '0;
                        wait_cnt      <= CNT_W'(TIMEOUT - 1);
                    end else if (beat_done && (state == BEAT0) && split_q) begin
                        // Next beat follows with no idle cycle; mem_req stays high.
                        state         <= BEAT1;
                        merge_q       <= bus.mem_rdata;
                        bus.mem_addr  <= bus.mem_addr + ADDR_W'(NB);
                        bus.mem_we    <= write_q ? we_win[2*NB-1:NB] : '0;
                        bus.mem_wdata <= write_q ? wd_win[2*DATA_W-1:DATA_W] : '0;
                        wait_cnt      <= CNT_W'(TIMEOUT - 1);
                    end else if (beat_done || timed_out) begin
                        state          <= RESP;
                        bus.mem_req    <= 1'b0;
                        bus.mem_we     <= '0;
                        bus.mem_wdata  <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= timed_out;
                        bus.resp_rdata <= (beat_done && !write_q) ? load_result : '0;
                    end else if (bus.mem_req) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized loads/stores
// checked against a byte-addressed big-endian memory model.
module tb_mem_access_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b ();
    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) nb ();

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .MISALIGN_SPLIT(1), .TIMEOUT(16))
        dut (.clock(clock), .reset_n(reset_n), .bus(b));
    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .MISALIGN_SPLIT(0), .TIMEOUT(16))
        dut_ns (.clock(clock), .reset_n(reset_n), .bus(nb));

    int vectors = 0;
    int errors  = 0;

    logic [31:0] words [128];
    logic [7:0]  ref_mem [512];
    int ack_delay = 0;
    int acks_left = -1;
    int beats_acked = 0;
    int req_cycles = 0;
    int ns_req_cycles = 0;
    logic [31:0] beat_addr [2];
    logic [3:0]  beat_we [2];
    logic [31:0] beat_wdata [2];

    logic        err_o;
    logic [31:0] rd_o;
    int          lat_o;
    logic        rdy_o;

    // Memory with programmable wait states; ack is driven on the falling edge so 0-wait means same cycle.
    initial begin : responder
        int waited;
        int idx;
        waited = 0;
        b.mem_ack = 1'b0;
        b.mem_rdata = '0;
        forever begin
            @(negedge clock);
            b.mem_ack = 1'b0;
            b.mem_rdata = $urandom;
            if (b.mem_req === 1'b1) begin
                req_cycles++;
                if (acks_left != 0 && waited >= ack_delay) begin
                    idx = int'(b.mem_addr[8:2]);
                    b.mem_ack = 1'b1;
                    b.mem_rdata = words[idx];
                    for (int i = 0; i < 4; i++)
                        if (b.mem_we[i]) words[idx][8*i +: 8] = b.mem_wdata[8*i +: 8];
                    if (beats_acked < 2) begin
                        beat_addr[beats_acked]  = b.mem_addr;
                        beat_we[beats_acked]    = b.mem_we;
                        beat_wdata[beats_acked] = b.mem_wdata;
                    end
                    beats_acked++;
                    if (acks_left > 0) acks_left--;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    initial begin : ns_responder
        nb.mem_ack = 1'b0;
        nb.mem_rdata = 32'h12345678;
        forever begin
            @(negedge clock);
            nb.mem_ack = (nb.mem_req === 1'b1);
            if (nb.mem_req === 1'b1) ns_req_cycles++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic access(input bit ns, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd, output int lat,
                          output logic ready_c1);
        bit got;
        got = 0; err = 1'b0; rd = '0; lat = 0; ready_c1 = 1'bx;
        @(negedge clock);
        beats_acked = 0; req_cycles = 0; ns_req_cycles = 0;
        if (ns) begin
            nb.req_valid = 1'b1; nb.req_write = wr; nb.req_size = sz;
            nb.req_signed = sg; nb.req_addr = a; nb.req_wdata = wd;
        end else begin
            b.req_valid = 1'b1; b.req_write = wr; b.req_size = sz;
            b.req_signed = sg; b.req_addr = a; b.req_wdata = wd;
        end
        @(posedge clock);
        #1;
        b.req_valid = 1'b0;
        nb.req_valid = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clock);
            lat++;
            if (lat == 1) ready_c1 = ns ? nb.req_ready : b.req_ready;
            if ((ns ? nb.resp_valid : b.resp_valid) === 1'b1) begin
                got = 1;
                err = ns ? nb.resp_err : b.resp_err;
                rd  = ns ? nb.resp_rdata : b.resp_rdata;
            end
        end
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL resp_wait: no resp_valid after %0d cycles, addr %h", lat, a);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input int s, input bit sg);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < s; k++) v = (v << 8) | 32'(ref_mem[int'(a) + k]);
        if (sg && s < 4 && v[8*s-1]) v = v | ~((32'd1 << (8 * s)) - 32'd1);
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({b.req_ready, b.mem_req, b.resp_valid, b.resp_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/req/valid/err %b want 1000",
                     {b.req_ready, b.mem_req, b.resp_valid, b.resp_err});
        end
        vectors++;
        if ({b.mem_addr, b.mem_we, b.mem_wdata, b.resp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h we %b wdata %h rdata %h want all 0",
                     b.mem_addr, b.mem_we, b.mem_wdata, b.resp_rdata);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (b.req_ready !== 1'b1 || b.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready %b req %b want 1 0", b.req_ready, b.mem_req);
        end
    endtask

    task automatic test_word_store();
        ack_delay = 0;
        words[64] = 32'h0;
        access(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (lat_o !== 3) begin errors++; $display("FAIL t1_latency: got %0d want 3", lat_o); end
        vectors++; if (err_o !== 1'b0 || rd_o !== 32'h0) begin errors++; $display("FAIL t1_resp: err %b rdata %h want 0 0", err_o, rd_o); end
        vectors++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL t1_ready_drop: got %b want 0", rdy_o); end
        vectors++; if (beats_acked !== 1) begin errors++; $display("FAIL t1_beats: got %0d want 1", beats_acked); end
        vectors++; if ({beat_addr[0], beat_we[0], beat_wdata[0]} !== {32'h100, 4'b1111, 32'hDEADBEEF}) begin
            errors++; $display("FAIL t1_beat: addr %h we %b wdata %h want 100 1111 deadbeef", beat_addr[0], beat_we[0], beat_wdata[0]); end
        vectors++; if (words[64] !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_mem: got %h want deadbeef", words[64]); end
        @(negedge clock);
        vectors++; if (b.req_ready !== 1'b1 || b.resp_valid !== 1'b0) begin
            errors++; $display("FAIL t1_after_resp: ready %b valid %b want 1 0", b.req_ready, b.resp_valid); end
    endtask

    task automatic test_byte_load();
        words[64] = 32'h000000F0;
        access(0, 0, 2'b00, 1, 32'h103, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (rd_o !== 32'hFFFFFFF0 || err_o !== 1'b0) begin errors++; $display("FAIL t2_signed: rdata %h err %b want fffffff0 0", rd_o, err_o); end
        vectors++; if (beat_we[0] !== 4'b0000 || lat_o !== 3) begin errors++; $display("FAIL t2_read_beat: we %b lat %0d want 0000 3", beat_we[0], lat_o); end
        access(0, 0, 2'b00, 0, 32'h103, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (rd_o !== 32'h000000F0) begin errors++; $display("FAIL t2_unsigned: rdata %h want 000000f0", rd_o); end
    endtask

    task automatic test_split_store();
        words[64] = 32'hA5A5A5A5;
        words[65] = 32'hA5A5A5A5;
        access(0, 1, 2'b10, 0, 32'h102, 32'h11223344, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (beats_acked !== 2 || lat_o !== 4 || err_o !== 1'b0) begin
            errors++; $display("FAIL t3_split: beats %0d lat %0d err %b want 2 4 0", beats_acked, lat_o, err_o); end
        vectors++; if ({beat_addr[0], beat_we[0], beat_wdata[0]} !== {32'h100, 4'b0011, 32'h00001122}) begin
            errors++; $display("FAIL t3_beat0: addr %h we %b wdata %h want 100 0011 00001122", beat_addr[0], beat_we[0], beat_wdata[0]); end
        vectors++; if ({beat_addr[1], beat_we[1], beat_wdata[1]} !== {32'h104, 4'b1100, 32'h33440000}) begin
            errors++; $display("FAIL t3_beat1: addr %h we %b wdata %h want 104 1100 33440000", beat_addr[1], beat_we[1], beat_wdata[1]); end
        vectors++; if (words[64] !== 32'hA5A51122 || words[65] !== 32'h3344A5A5) begin
            errors++; $display("FAIL t3_mem: got %h %h want a5a51122 3344a5a5", words[64], words[65]); end
    endtask

    task automatic test_split_load();
        words[64] = 32'hAABBCCDD;
        words[65] = 32'hEEFF0011;
        access(0, 0, 2'b10, 0, 32'h101, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (rd_o !== 32'hBBCCDDEE || beats_acked !== 2 || lat_o !== 4) begin
            errors++; $display("FAIL t4_word: rdata %h beats %0d lat %0d want bbccddee 2 4", rd_o, beats_acked, lat_o); end
        access(0, 0, 2'b01, 1, 32'h103, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (rd_o !== 32'hFFFFDDEE || beats_acked !== 2) begin
            errors++; $display("FAIL t4_half_signed: rdata %h beats %0d want ffffddee 2", rd_o, beats_acked); end
    endtask

    task automatic test_reject();
        access(1, 0, 2'b01, 0, 32'h003, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (err_o !== 1'b1 || rd_o !== 32'h0 || ns_req_cycles !== 0) begin
            errors++; $display("FAIL t5_misalign_reject: err %b rdata %h req_cycles %0d want 1 0 0", err_o, rd_o, ns_req_cycles); end
        access(1, 0, 2'b01, 0, 32'h001, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (err_o !== 1'b0 || rd_o !== 32'h00003456 || ns_req_cycles !== 1) begin
            errors++; $display("FAIL t5_inword_half: err %b rdata %h req_cycles %0d want 0 00003456 1", err_o, rd_o, ns_req_cycles); end
        access(0, 1, 2'b11, 0, 32'h100, 32'h12345678, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (err_o !== 1'b1 || req_cycles !== 0) begin
            errors++; $display("FAIL t5_illegal_size: err %b req_cycles %0d want 1 0", err_o, req_cycles); end
    endtask

    task automatic test_timeout();
        acks_left = 0;
        access(0, 0, 2'b10, 0, 32'h100, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (err_o !== 1'b1 || rd_o !== 32'h0) begin errors++; $display("FAIL t6_err: err %b rdata %h want 1 0", err_o, rd_o); end
        vectors++; if (req_cycles !== 16 || lat_o !== 18) begin
            errors++; $display("FAIL t6_timing: req_cycles %0d lat %0d want 16 18", req_cycles, lat_o); end
        acks_left = 1;
        words[65] = 32'h11111111;
        words[66] = 32'h22222222;
        access(0, 1, 2'b10, 0, 32'h106, 32'hCAFEF00D, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (err_o !== 1'b1 || beats_acked !== 1 || req_cycles !== 17) begin
            errors++; $display("FAIL t6_partial: err %b beats %0d req_cycles %0d want 1 1 17", err_o, beats_acked, req_cycles); end
        vectors++; if (words[65] !== 32'h1111CAFE || words[66] !== 32'h22222222) begin
            errors++; $display("FAIL t6_partial_mem: got %h %h want 1111cafe 22222222", words[65], words[66]); end
        acks_left = -1;
    endtask

    task automatic test_reset_mid();
        int n;
        acks_left = 1;
        ack_delay = 0;
        @(negedge clock);
        beats_acked = 0;
        b.req_valid = 1'b1; b.req_write = 1'b0; b.req_size = 2'b10;
        b.req_signed = 1'b0; b.req_addr = 32'h103; b.req_wdata = 32'h0;
        @(posedge clock);
        #1;
        b.req_valid = 1'b0;
        n = 0;
        while (beats_acked < 1 && n < 50) begin @(negedge clock); n++; end
        @(negedge clock);
        vectors++; if (b.mem_req !== 1'b1 || beats_acked !== 1) begin
            errors++; $display("FAIL t6_reach_beat1: req %b beats %0d want 1 1", b.mem_req, beats_acked); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (b.mem_req !== 1'b0 || b.resp_valid !== 1'b0 || b.mem_we !== 4'b0) begin
            errors++; $display("FAIL t6_async_reset: req %b valid %b we %b want 0 0 0", b.mem_req, b.resp_valid, b.mem_we); end
        @(negedge clock);
        reset_n = 1'b1;
        acks_left = -1;
        @(negedge clock);
        vectors++; if (b.req_ready !== 1'b1 || b.mem_req !== 1'b0) begin
            errors++; $display("FAIL t6_after_reset: ready %b req %b want 1 0", b.req_ready, b.mem_req); end
        words[64] = 32'h5A5AC3C3;
        access(0, 0, 2'b10, 0, 32'h100, 32'h0, err_o, rd_o, lat_o, rdy_o);
        vectors++; if (rd_o !== 32'h5A5AC3C3 || err_o !== 1'b0) begin
            errors++; $display("FAIL t6_recover: rdata %h err %b want 5a5ac3c3 0", rd_o, err_o); end
    endtask

    task automatic test_back_to_back();
        bit          wr, sg;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp_rd, exp_word;
        int          s, exp_beats, exp_lat;
        for (int i = 0; i < 128; i++) begin
            words[i] = $urandom;
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = words[i][8*(3-j) +: 8];
        end
        for (int t = 0; t < 80; t++) begin
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            s  = 1 << sz;
            a  = 32'h100 + 32'($urandom_range(0, 127));
            wd = $urandom;
            ack_delay = $urandom_range(0, 3);
            exp_beats = ((int'(a % 4) + s) > 4) ? 2 : 1;
            exp_lat   = 2 + exp_beats * (ack_delay + 1);
            exp_rd    = wr ? 32'h0 : model_load(a, s, sg);
            if (wr) for (int k = 0; k < s; k++) ref_mem[int'(a) + k] = wd[8*(s-1-k) +: 8];
            access(0, wr, sz, sg, a, wd, err_o, rd_o, lat_o, rdy_o);
            vectors++; if (err_o !== 1'b0 || rd_o !== exp_rd) begin
                errors++; $display("FAIL rnd_resp[%0d]: wr %b size %0d addr %h err %b rdata %h want 0 %h", t, wr, sz, a, err_o, rd_o, exp_rd); end
            vectors++; if (beats_acked !== exp_beats || lat_o !== exp_lat) begin
                errors++; $display("FAIL rnd_timing[%0d]: addr %h size %0d beats %0d lat %0d want %0d %0d", t, a, sz, beats_acked, lat_o, exp_beats, exp_lat); end
        end
        for (int i = 64; i < 98; i++) begin
            exp_word = {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]};
            vectors++; if (words[i] !== exp_word) begin
                errors++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, words[i], exp_word); end
        end
        ack_delay = 0;
    endtask

    initial begin
        b.req_valid = 1'b0; b.req_write = 1'b0; b.req_size = 2'b00;
        b.req_signed = 1'b0; b.req_addr = '0; b.req_wdata = '0;
        nb.req_valid = 1'b0; nb.req_write = 1'b0; nb.req_size = 2'b00;
        nb.req_signed = 1'b0; nb.req_addr = '0; nb.req_wdata = '0;
        for (int i = 0; i < 128; i++) words[i] = '0;
        test_reset();
        test_word_store();
        test_byte_load();
        test_split_store();
        test_split_load();
        test_reject();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
